wrr_burst_arbiter: RTL

//  Weighted round-robin arbiter that shares one transaction resource among N requesters.

---
 rtl/wrr_burst_arbiter.sv | 61 ++++++
 1 files changed

// File: rtl/wrr_burst_arbiter.sv
// wrr_burst_arbiter: weighted round-robin arbiter that holds each grant for a burst of up to weight[i] transactions
module wrr_burst_arbiter #(
  parameter int N     = 4,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*CNT_W-1:0]   weight,
  input  logic                 done,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy
);
  localparam int IW = $clog2(N);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t           r_state;
  logic [IW-1:0]    r_ptr;
  logic [CNT_W-1:0] r_credit;
  logic             w_release;
  logic [IW-1:0]    w_ptr;
  logic [IW-1:0]    w_sel;
  logic             w_found;
  logic [CNT_W-1:0] w_wt;
  logic [CNT_W-1:0] w_credit;
  // release decision, rotated search start, and first requester at or after it (lowest offset wins)
  always_comb begin
    w_release = (r_state == GRANT) && done && (r_credit <= CNT_W'(1) || !req[grant_id]);
    w_ptr     = w_release ? ((grant_id == IW'(N-1)) ? '0 : grant_id + IW'(1)) : r_ptr;
    w_sel     = '0;
    w_found   = 1'b0;
    for (int k = N-1; k >= 0; k--) begin
      if (req[(int'(w_ptr) + k) % N]) begin
        w_sel   = IW'((int'(w_ptr) + k) % N);
        w_found = 1'b1;
      end
    end
    w_wt     = weight[w_sel*CNT_W +: CNT_W];
    w_credit = (w_wt == '0) ? CNT_W'(1) : w_wt;
  end
  // grant FSM: load a new owner from idle or on release (no bubble), otherwise count down the burst
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_credit <= '0;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else if ((r_state == IDLE) || w_release) begin
      r_ptr    <= w_ptr;
      r_state  <= w_found ? GRANT : IDLE;
      r_credit <= w_found ? w_credit : '0;
      grant    <= w_found ? (N'(1) << w_sel) : '0;
      grant_id <= w_found ? w_sel : '0;
      busy     <= w_found;
    end else if (done) begin
      r_credit <= r_credit - CNT_W'(1);
    end
  end
endmodule
